// File: rtl/dqs_seq_pkg.sv
// dqs_seq_pkg: shared state encoding and DQS drive patterns for the write strobe sequencer
package dqs_seq_pkg;
  typedef enum logic [1:0] {IDLE, PRE, BURST, POST} state_t;
  localparam logic [1:0] DQS_LOW    = 2'b00;
  localparam logic [1:0] DQS_TOGGLE = 2'b01;
endpackage

// File: rtl/dqs_wr_seq.sv
// dqs_wr_seq: DQS/DQ write-burst sequencer (tristate, preamble, burst, postamble) for one byte lane
module dqs_wr_seq
  import dqs_seq_pkg::*;
#(
  parameter int PRE_CYCLES  = 1,
  parameter int POST_CYCLES = 1,
  parameter int LEN_WIDTH   = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic [LEN_WIDTH-1:0] req_len,
  output logic                 req_ready,
  input  logic                 abort,
  output logic [1:0]           dqs_din,
  output logic                 dqs_tin,
  output logic                 dq_tin,
  output logic                 data_en,
  output logic                 busy,
  output logic                 done
);
  localparam int PW = $clog2((PRE_CYCLES > POST_CYCLES ? PRE_CYCLES : POST_CYCLES) + 1);
  localparam logic [PW-1:0] PRE_LOAD  = PW'(PRE_CYCLES - 1);
  localparam logic [PW-1:0] POST_LOAD = PW'(POST_CYCLES - 1);
  state_t state, nxt;
  logic [LEN_WIDTH-1:0] beat_cnt, beat_nxt;
  logic [PW-1:0] ph_cnt, ph_nxt;
  logic last_beat, accept;
  assign last_beat = beat_cnt == '0;
  assign req_ready = (state == IDLE || (state == BURST && last_beat)) && !abort;
  assign accept    = req_valid && req_ready;
  always_comb begin
    nxt      = state;
    beat_nxt = beat_cnt;
    ph_nxt   = ph_cnt;
    case (state)
      IDLE: if (accept) begin
        nxt      = PRE;
        beat_nxt = req_len;
        ph_nxt   = PRE_LOAD;
      end
      PRE: if (abort) begin
        nxt    = POST;
        ph_nxt = POST_LOAD;
      end else if (ph_cnt == '0) nxt = BURST;
      else ph_nxt = ph_cnt - 1'b1;
      BURST: if (abort || (last_beat && !accept)) begin
        nxt      = POST;
        beat_nxt = '0;
        ph_nxt   = POST_LOAD;
      end else beat_nxt = last_beat ? req_len : beat_cnt - 1'b1;
      default: if (ph_cnt == '0) nxt = IDLE;
      else ph_nxt = ph_cnt - 1'b1;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      ph_cnt   <= '0;
      dqs_din  <= DQS_LOW;
      dqs_tin  <= 1'b1;
      dq_tin   <= 1'b1;
      data_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= nxt;
      beat_cnt <= beat_nxt;
      ph_cnt   <= ph_nxt;
      dqs_din  <= nxt == BURST ? DQS_TOGGLE : DQS_LOW;
      dqs_tin  <= nxt == IDLE;
      dq_tin   <= nxt != BURST;
      data_en  <= nxt == BURST;
      busy     <= nxt != IDLE;
      done     <= state == POST && nxt == IDLE;
    end
  end
endmodule

// File: tb/tb_dqs_wr_seq.sv
// tb_dqs_wr_seq: directed self-checking bench for dqs_wr_seq (default and PRE=2/POST=3 instances)
module tb_dqs_wr_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  logic v1 = 1'b0, a1 = 1'b0, v2 = 1'b0, a2 = 1'b0;
  logic [5:0] l1 = '0, l2 = '0;
  logic r1, r2, t1, t2, qt1, qt2, de1, de2, b1, b2, d1, d2;
  logic [1:0] din1, din2;
  logic [6:0] o1, o2;
  int total = 0, bad = 0;
  // {busy, done, data_en, dq_tin, dqs_tin, dqs_din}
  localparam logic [6:0] S_IDLE  = 7'b0_0_0_1_1_00;
  localparam logic [6:0] S_DONE  = 7'b0_1_0_1_1_00;
  localparam logic [6:0] S_PRE   = 7'b1_0_0_1_0_00;
  localparam logic [6:0] S_BURST = 7'b1_0_1_0_0_01;
  localparam logic [6:0] S_POST  = 7'b1_0_0_1_0_00;

  always #5 clk = ~clk;

  dqs_wr_seq u1 (.clk(clk), .rst_n(rst_n), .req_valid(v1), .req_len(l1), .req_ready(r1),
    .abort(a1), .dqs_din(din1), .dqs_tin(t1), .dq_tin(qt1), .data_en(de1), .busy(b1), .done(d1));
  dqs_wr_seq #(.PRE_CYCLES(2), .POST_CYCLES(3)) u2 (.clk(clk), .rst_n(rst_n), .req_valid(v2),
    .req_len(l2), .req_ready(r2), .abort(a2), .dqs_din(din2), .dqs_tin(t2), .dq_tin(qt2),
    .data_en(de2), .busy(b2), .done(d2));

  assign o1 = {b1, d1, de1, qt1, t1, din1};
  assign o2 = {b2, d2, de2, qt2, t2, din2};

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    repeat (2) tick();
    chk("reset_hold", o1, S_IDLE);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", o1, S_IDLE);
    chk("ready_idle", {6'b0, r1}, 7'd1);
    // single burst, req_len=3
    v1 = 1'b1; l1 = 6'd3;
    tick();
    v1 = 1'b0;
    chk("single_pre", o1, S_PRE);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("single_burst%0d", i), o1, S_BURST);
    end
    tick();
    chk("single_post", o1, S_POST);
    tick();
    chk("single_done", o1, S_DONE);
    tick();
    chk("single_idle", o1, S_IDLE);
    // back-to-back: 4 beats then 2 beats seamlessly
    v1 = 1'b1; l1 = 6'd3;
    tick();
    v1 = 1'b0;
    chk("b2b_pre", o1, S_PRE);
    tick();
    chk("b2b_ready_mid", {6'b0, r1}, 7'd0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_burst%0d", i), o1, S_BURST);
      tick();
    end
    chk("b2b_burst3", o1, S_BURST);
    chk("b2b_ready_last", {6'b0, r1}, 7'd1);
    v1 = 1'b1; l1 = 6'd1;
    tick();
    v1 = 1'b0;
    chk("b2b_burst4", o1, S_BURST);
    tick();
    chk("b2b_burst5", o1, S_BURST);
    tick();
    chk("b2b_post", o1, S_POST);
    tick();
    chk("b2b_done", o1, S_DONE);
    // abort on second burst cycle of req_len=7
    v1 = 1'b1; l1 = 6'd7;
    tick();
    l1 = 6'd0;
    chk("abort_pre", o1, S_PRE);
    tick();
    chk("abort_burst0", o1, S_BURST);
    tick();
    a1 = 1'b1;
    #1;
    chk("abort_ready_low", {6'b0, r1}, 7'd0);
    tick();
    a1 = 1'b0;
    chk("abort_post", o1, S_POST);
    chk("abort_post_ready", {6'b0, r1}, 7'd0);
    tick();
    chk("abort_done", o1, S_DONE);
    tick();
    v1 = 1'b0;
    chk("abort_reaccept_pre", o1, S_PRE);
    tick();
    chk("abort_reaccept_burst", o1, S_BURST);
    tick();
    chk("abort_reaccept_post", o1, S_POST);
    tick();
    chk("abort_reaccept_done", o1, S_DONE);
    // PRE=2, POST=3, req_len=0 on the second instance
    v2 = 1'b1; l2 = 6'd0;
    tick();
    v2 = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("p2_step%0d", i), o2, i < 2 ? S_PRE : (i == 2 ? S_BURST : S_POST));
      if (!t2) n++;
      tick();
    end
    chk("p2_done", o2, S_DONE);
    chk("p2_tin_low_count", 7'(n), 7'd6);
    // maximum length burst
    v1 = 1'b1; l1 = 6'd63;
    tick();
    v1 = 1'b0;
    chk("max_pre", o1, S_PRE);
    tick();
    n = 0;
    while (de1 && n < 100) begin
      n++;
      tick();
    end
    chk("max_beats", 7'(n), 7'd64);
    chk("max_post", o1, S_POST);
    tick();
    chk("max_done", o1, S_DONE);
    // asynchronous reset in the middle of a burst
    v1 = 1'b1; l1 = 6'd7;
    tick();
    v1 = 1'b0;
    tick();
    chk("rst_pre_burst", o1, S_BURST);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_burst", o1, S_IDLE);
    tick();
    chk("rst_held", o1, S_IDLE);
    rst_n = 1'b1;
    tick();
    chk("rst_release", o1, S_IDLE);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
